// File: rtl/sync_fifo_pkg.sv
// Shared types for the lane-interleave reader.
//   lane_idx_t : lane index register type. It is wide enough for any supported
//                lane count; users slice it down to $clog2(NUM_LANES) bits.
//   count_t    : occupancy of a 2-entry buffer (0..2).
//   lane_next  : round-robin successor of a lane index, wrapping at num_lanes.
package sync_fifo_pkg;

  localparam int LANE_IDX_W = 8;

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;
  typedef logic [1:0]            count_t;

  function automatic lane_idx_t lane_next(input lane_idx_t cur, input int num_lanes);
    if (cur == lane_idx_t'(num_lanes - 1)) begin
      return '0;
    end
    return cur + lane_idx_t'(1);
  endfunction

endpackage

// File: rtl/sync_skid_buffer.sv
// Two-entry output buffer (main slot + skid slot).
// The main slot drives out_data/out_valid directly. The skid slot catches the
// one word that may arrive while the main slot is stalled, which lets in_ready
// be a plain register output with no path from out_ready.
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   clear                : synchronous flush of both slots
//   in_data/in_valid/in_ready    : upstream side
//   out_data/out_valid/out_ready : downstream side
//   count                : number of occupied slots (0..2)
module sync_skid_buffer
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output count_t                count
);

  logic                  main_valid;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] main_data;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  accept;
  logic                  pop;

  // Ready depends only on the skid slot: while it is empty there is always
  // room for one more word, whatever the downstream does this cycle.
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign pop      = main_valid && out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (clear) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || pop) begin
      // Main slot frees up this edge: the older skid word goes first.
      if (skid_valid) begin
        main_data  <= skid_data;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept;
        if (accept) begin
          main_data <= in_data;
        end
      end
    end else if (accept) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

  assign out_data  = main_data;
  assign out_valid = main_valid;
  assign count     = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: rtl/sync_interleave_reader.sv
// Reassembles a stream that was striped round-robin over NUM_LANES lane FIFOs,
// starting at lane 0, into a single in-order stream.
// Ports:
//   clk, rstn                        : clock, asynchronous active-low reset
//   lane_data/lane_valid/lane_ready  : per-lane FIFO read ports
//   out_data/out_valid/out_ready     : merged output stream
//   clear                            : synchronous flush (buffer and lane pointer)
//   lane_sel                         : lane expected next
//   count                            : words held in the output buffer
//
// Handshakes: a word moves across an interface on a rising edge where its valid
// and ready are both high; a producer holds valid and data stable until that
// edge, and ready never depends combinationally on the valid it is paired with.
// Here lane_ready comes from registered state (plus clear and reset), never
// from out_ready.
module sync_interleave_reader
  import sync_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH   = 8,
  parameter  int NUM_LANES    = 2,
  localparam int LB_NUM_LANES = $clog2(NUM_LANES)
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_data,
  input  logic [NUM_LANES-1:0]                 lane_valid,
  output logic [NUM_LANES-1:0]                 lane_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  input  logic                                 clear,
  output logic [LB_NUM_LANES-1:0]              lane_sel,
  output count_t                               count
);

  lane_idx_t             sel_q;
  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  buf_in_ready;
  logic                  lane_accept;

  // Only the selected lane is looked at; other lanes wait even if valid, so a
  // late lane stalls the merge instead of letting words overtake it.
  always_comb begin
    sel_valid  = 1'b0;
    sel_data   = '0;
    lane_ready = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_idx_t'(i) == sel_q) begin
        sel_valid     = lane_valid[i];
        sel_data      = lane_data[i];
        // rstn gating keeps ready low while reset is asserted.
        lane_ready[i] = rstn && buf_in_ready && !clear;
      end
    end
  end

  assign lane_accept = sel_valid && buf_in_ready && !clear;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_q <= '0;
    end else if (clear) begin
      sel_q <= '0;
    end else if (lane_accept) begin
      sel_q <= lane_next(sel_q, NUM_LANES);
    end
  end

  assign lane_sel = sel_q[LB_NUM_LANES-1:0];

  sync_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (clear),
    .in_data  (sel_data),
    .in_valid (sel_valid && !clear),
    .in_ready (buf_in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count)
  );

endmodule

// File: tb/tb_sync_interleave_reader.sv
// Bench for sync_interleave_reader (DATA_WIDTH=8, NUM_LANES=2).
// Lane sources are bench queues; a queue model of the output buffer and the
// expected lane pointer is checked every cycle, and a stream scoreboard
// (exp_q) checks every word leaving the DUT against the expected order.
module tb_sync_interleave_reader;

  logic            clk;
  logic            rstn;
  logic [1:0][7:0] lane_data;
  logic [1:0]      lane_valid;
  logic [1:0]      lane_ready;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_ready;
  logic            clear;
  logic [0:0]      lane_sel;
  logic [1:0]      count;

  sync_interleave_reader #(
    .DATA_WIDTH(8),
    .NUM_LANES (2)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .lane_data (lane_data),
    .lane_valid(lane_valid),
    .lane_ready(lane_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .clear     (clear),
    .lane_sel  (lane_sel),
    .count     (count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_out    = 0;
  bit         cmp_en   = 1'b0;
  logic [1:0] lane_en  = 2'b00;
  logic [7:0] src0_q[$];
  logic [7:0] src1_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] buf_q[$];
  int         m_sel = 0;
  logic [7:0] dummy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_lanes();
    lane_valid[0] = lane_en[0] && (src0_q.size() > 0);
    lane_data[0]  = (src0_q.size() > 0) ? src0_q[0] : 8'h00;
    lane_valid[1] = lane_en[1] && (src1_q.size() > 0);
    lane_data[1]  = (src1_q.size() > 0) ? src1_q[0] : 8'h00;
  endtask

  always @(posedge clk) begin
    #2;
    drive_lanes();
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || buf_q.size() > 0 || src0_q.size() > 0 || src1_q.size() > 0)
           && n < max_cyc) begin
      cyc();
      n++;
    end
    n_checks++;
    if (n >= max_cyc) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d words still pending after %0d cycles", name, exp_q.size(), n);
    end
  endtask

  // ---------------- model: buffer of up to 2 words, next lane in rotation ----------------
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_q.delete();
      m_sel = 0;
    end else if (clear) begin
      buf_q.delete();
      m_sel = 0;
    end else begin
      bit acc, pop;
      acc = lane_valid[m_sel] && (buf_q.size() < 2);
      pop = (buf_q.size() > 0) && out_ready;
      if (pop) dummy = buf_q.pop_front();
      if (acc) begin
        buf_q.push_back(lane_data[m_sel]);
        if (m_sel == 0) dummy = src0_q.pop_front();
        else            dummy = src1_q.pop_front();
        m_sel = (m_sel + 1) % 2;
      end
    end
  end

  // ---------------- compare + stream scoreboard ----------------
  always @(negedge clk) begin
    if (rstn && cmp_en) begin
      logic [1:0] exp_ready;
      check("out_valid", 32'(out_valid), 32'(buf_q.size() > 0));
      if (buf_q.size() > 0) check("out_data", 32'(out_data), 32'(buf_q[0]));
      check("count", 32'(count), 32'(buf_q.size()));
      check("count_max", 32'(count <= 2'd2), 32'd1);
      check("lane_sel", 32'(lane_sel), 32'(m_sel));
      exp_ready = (buf_q.size() < 2 && !clear) ? (2'b01 << m_sel) : 2'b00;
      check("lane_ready", 32'(lane_ready), 32'(exp_ready));
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL stream_extra: got word %0h expected no word at %0t", out_data, $time);
        end else begin
          check("stream_word", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] seq_036[4];
    int         n;
    int         out_start;
    logic [7:0] w;
    seq_036 = '{8'h11, 8'h22, 8'h33, 8'h44};

    rstn       = 1'b0;
    out_ready  = 1'b0;
    clear      = 1'b0;
    lane_valid = 2'b00;
    lane_data  = '0;

    // reset held 100 cycles
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_lane_ready", 32'(lane_ready), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    check("rel_out_valid", 32'(out_valid), 32'd0);
    check("rel_count", 32'(count), 32'd0);
    check("rel_lane_sel", 32'(lane_sel), 32'd0);
    check("rel_lane_ready", 32'(lane_ready), 32'b01);

    // in-order streaming, one word per cycle
    cyc();
    src0_q = '{8'h11, 8'h33};
    src1_q = '{8'h22, 8'h44};
    exp_q  = '{8'h11, 8'h22, 8'h33, 8'h44};
    lane_en   = 2'b11;
    out_ready = 1'b1;
    @(negedge clk);
    check("stream_pre_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stream_seq_valid", 32'(out_valid), 32'd1);
      check("stream_seq_data", 32'(out_data), 32'(seq_036[k]));
    end
    @(negedge clk);
    check("stream_post_valid", 32'(out_valid), 32'd0);
    drain("stream", 50);

    // backpressure: two accepted, third held off
    cyc();
    out_ready = 1'b0;
    src0_q = '{8'hA0, 8'hA2};
    src1_q = '{8'hA1};
    exp_q  = '{8'hA0, 8'hA1, 8'hA2};
    repeat (4) cyc();
    @(negedge clk);
    check("bp_count", 32'(count), 32'd2);
    check("bp_lane_ready", 32'(lane_ready), 32'd0);
    check("bp_out_data", 32'(out_data), 32'hA0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    cyc();
    out_ready = 1'b1;
    drain("backpressure", 50);

    // clear on an empty buffer brings the lane pointer back to 0
    cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    @(negedge clk);
    check("clr_empty_sel", 32'(lane_sel), 32'd0);

    // lane stall: lane1 valid, lane0 not
    cyc();
    src1_q = '{8'h55};
    exp_q  = '{8'h66, 8'h55};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_sel", 32'(lane_sel), 32'd0);
      check("stall_count", 32'(count), 32'd0);
      check("stall_valid", 32'(out_valid), 32'd0);
    end
    cyc();
    src0_q.push_back(8'h66);
    drain("stall", 50);

    // clear with count=2 and lane_sel=1
    cyc();
    src0_q = '{8'hC0};
    exp_q  = '{8'hC0};
    drain("clear_prep", 50);
    cyc();
    out_ready = 1'b0;
    src0_q = '{8'hC2, 8'hC4};
    src1_q = '{8'hC1, 8'hC3};
    repeat (4) cyc();
    @(negedge clk);
    check("clr_pre_count", 32'(count), 32'd2);
    check("clr_pre_sel", 32'(lane_sel), 32'd1);
    cyc();
    clear = 1'b1;
    @(negedge clk);
    check("clr_lane_ready", 32'(lane_ready), 32'd0);
    cyc();
    @(negedge clk);
    check("clr_count", 32'(count), 32'd0);
    check("clr_out_valid", 32'(out_valid), 32'd0);
    check("clr_sel", 32'(lane_sel), 32'd0);
    check("clr_hold_ready", 32'(lane_ready), 32'd0);
    cyc();
    clear     = 1'b0;
    out_ready = 1'b1;
    exp_q     = '{8'hC4, 8'hC3};
    drain("clear", 50);

    // random traffic
    cyc();
    out_start = n_out;
    for (int k = 0; k < 1000; k++) begin
      w = 8'($urandom_range(0, 255));
      if (k % 2 == 0) src0_q.push_back(w);
      else            src1_q.push_back(w);
      exp_q.push_back(w);
    end
    n = 0;
    while (exp_q.size() > 0 && n < 20000) begin
      cyc();
      lane_en   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    n_checks++;
    if (n >= 20000) begin
      n_fail++;
      $display("FAIL random_timeout: %0d words still pending", exp_q.size());
    end
    check("random_words", 32'(n_out - out_start), 32'd1000);
    cyc();
    lane_en   = 2'b11;
    out_ready = 1'b1;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_interleave_reader.md
SYNC_INTERLEAVE_READER -- requirements
Module: sync_interleave_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the payload width in bits.
REQ-002 SHALL have parameter NUM_LANES, default 2, meaning the number of interleaved lanes; legal values are powers of two, 2 or greater.
REQ-003 SHALL have localparam LB_NUM_LANES = $clog2(NUM_LANES).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port lane_data, input, NUM_LANES x DATA_WIDTH: per-lane payload, one word per lane FIFO output.
REQ-007 SHALL have port lane_valid, input, NUM_LANES: per-lane valid.
REQ-008 SHALL have port lane_ready, output, NUM_LANES: per-lane ready.
REQ-009 SHALL have port out_data, output, DATA_WIDTH: merged stream payload.
REQ-010 SHALL have port out_valid, output, 1 bit: merged stream valid.
REQ-011 SHALL have port out_ready, input, 1 bit: merged stream ready from the downstream consumer.
REQ-012 SHALL have port clear, input, 1 bit: synchronous flush.
REQ-013 SHALL have port lane_sel, output, LB_NUM_LANES bits: index of the lane expected next.
REQ-014 SHALL have port count, output, 2 bits: number of words held in the output buffer (0 to 2).

Function
REQ-015 SHALL reassemble a stream that was striped round-robin across lanes, starting at lane 0, emitting words in strict lane order 0,1,...,NUM_LANES-1,0,...
REQ-016 SHALL accept a lane transfer only when lane_valid[i] and lane_ready[i] are both high on a rising edge.
REQ-017 SHALL assert lane_ready[i] only when i equals lane_sel, the skid slot is empty, and clear is low; all other lanes SHALL be held at ready 0.
REQ-018 SHALL derive lane_ready from registered state only, with no combinational path from out_ready.
REQ-019 SHALL increment lane_sel modulo NUM_LANES on every accepted lane transfer, wrapping from NUM_LANES-1 to 0.
REQ-020 SHALL NOT advance lane_sel or accept data from any other lane while lane_valid[lane_sel] is low, even if other lanes are valid.
REQ-021 SHALL use a 2-entry output buffer (main slot plus skid slot); out_data/out_valid SHALL come directly from the main-slot registers.
REQ-022 SHALL have a latency of 1 cycle: a word accepted at edge N appears with out_valid high after edge N.
REQ-023 SHALL sustain a throughput of one word per cycle while out_ready is held high.
REQ-024 SHALL, on an accept while the main slot is full and out_ready is low, capture the word in the skid slot; lane_ready SHALL be 0 from the next cycle.
REQ-025 SHALL, when the main slot drains with the skid slot full, move the skid word to the main slot in the same edge, preserving order.
REQ-026 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-027 SHALL keep count equal to the number of occupied slots, updated on the same edge as the transfer.
REQ-028 SHALL, on simultaneous accept and pop, leave count unchanged.
REQ-029 SHALL, when clear=1 at an edge, empty both slots, set lane_sel=0 and count=0; clear SHALL take priority over a simultaneous accept or pop.
REQ-030 SHALL NOT consume any lane word while clear=1.

Reset
REQ-031 SHALL, while rstn=0, asynchronously force out_valid=0, lane_ready=0, lane_sel=0, count=0, out_data=0, and empty both slots.
REQ-032 SHALL assert lane_ready[0] on the first cycle after rstn deasserts; a transfer in progress is discarded by reset.

Structure
REQ-033 SHALL take the lane-index type and the count type from the shared package sync_fifo_pkg.
REQ-034 SHALL implement the 2-entry output buffer as sub-module sync_skid_buffer (DATA_WIDTH parameter; in/out valid/ready, clear, count); lane selection stays in the top module.

Verification
REQ-035 SHALL verify reset: hold rstn=0 for 100 cycles, then release -> out_valid=0, count=0, lane_sel=0, lane_ready=2'b01.
REQ-036 SHALL verify in-order streaming: lane0 presents 8'h11,8'h33 and lane1 presents 8'h22,8'h44, with out_ready=1 -> out_data sequence 11,22,33,44 on consecutive cycles, one cycle after each accept.
REQ-037 SHALL verify backpressure: out_ready=0, with lanes offering 8'hA0 (lane0), 8'hA1 (lane1), 8'hA2 (lane0) -> two words accepted, count=2, lane_ready=0, out_data=A0 held; after out_ready=1 -> outputs A0, A1, A2 in order.
REQ-038 SHALL verify lane stall: lane1 valid with lane0 invalid for 5 cycles -> no acceptance and lane_sel stays 0; then lane0 valid -> lane0 word is emitted first.
REQ-039 SHALL verify clear: with count=2 and lane_sel=1, pulse clear with lane_valid=2'b11 -> next cycle count=0, out_valid=0, lane_sel=0, and no lane word consumed in the clear cycle.
REQ-040 SHALL verify random traffic: 1000 words with random lane_valid and random out_ready against a queue model -> every word matches in order and count is never above 2.
